muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair for the MIPS32 core.
- Accepts MULT/MULTU/DIV/DIVU by funct code and runs a WIDTH-step shift-add or restoring-divide loop.
- Also services MTHI/MTLO writes.
- Raises a stall to the pipeline while a new op or a HI/LO read arrives during a busy period.
- Sits beside the ALU and its control decoder; consumes rs/rt values and the instruction funct field.

---
 rtl/muldiv_seq.sv | 109 ++++++++++
 tb/tb_muldiv_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MIPS32 multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one step per cycle on magnitudes.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic             read_req,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0]   b_q, hi_q, lo_q, a_mag, b_mag;
    logic [WIDTH:0]     sum_d, shl_d, diff_d;
    logic               busy_q, done_q, dz_out_q, is_div_q, neg_q, rneg_q, dz_q;
    logic               is_op, sgn, dz;
    always_comb begin
        is_op  = start && func[5:2] == 4'b0110;
        sgn    = !func[0];
        dz     = func[1] && rt_val == '0;
        a_mag  = (sgn && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        b_mag  = (sgn && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
        sum_d  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shl_d  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        diff_d = shl_d - {1'b0, b_q};
        p_d    = !is_div_q ? {sum_d, p_q[WIDTH-1:1]} :
                 diff_d[WIDTH] ? {shl_d[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0} :
                                 {diff_d[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_op) begin
                        state_q  <= dz ? FIN : CALC;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        is_div_q <= func[1];
                        dz_q     <= dz;
                        neg_q    <= sgn && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        rneg_q   <= sgn && rs_val[WIDTH-1];
                        b_q      <= func[1] ? b_mag : a_mag;
                        p_q      <= dz ? {rs_val, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, func[1] ? a_mag : b_mag};
                    end else if (start && func == 6'd17) begin
                        hi_q <= rs_val;
                    end else if (start && func == 6'd19) begin
                        lo_q <= rs_val;
                    end
                end
                CALC: begin
                    p_q     <= p_d;
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= cnt_q == CW'(WIDTH-1) ? FIN : CALC;
                end
                FIN: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    dz_out_q <= dz_q;
                    if (dz_q) begin
                        hi_q <= p_q[2*WIDTH-1:WIDTH];
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                        lo_q <= neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                    end else begin
                        {hi_q, lo_q} <= neg_q ? -p_q : p_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign stall       = busy_q && (start || read_req);
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: vector table, hand-written corner sequences and random ops against a 64-bit arithmetic model.
module tb_muldiv_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, read_req = 1'b0;
    logic [5:0]  func = '0;
    logic [31:0] rs_val = '0, rt_val = '0, hi, lo;
    logic        busy, done, div_by_zero, stall;
    int          tests = 0, fails = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func(func), .read_req(read_req),
        .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, ehi, elo;
        logic        edz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo, output logic mdz);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        mdz = 1'b0;
        if (f == 6'd24) begin
            q = sa * sb;
            {mhi, mlo} = q;
        end else if (f == 6'd25) begin
            p = ua * ub;
            {mhi, mlo} = p;
        end else if (b == 0) begin
            mdz = 1'b1;
            mhi = a;
            mlo = '1;
        end else if (f == 6'd26) begin
            q = sa / sb;
            r = sa % sb;
            mlo = q[31:0];
            mhi = r[31:0];
        end else begin
            mlo = 32'(ua / ub);
            mhi = 32'(ua % ub);
        end
    endfunction

    // Accepts one op and waits (bounded) for done; lat counts cycles from the accept edge.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bc);
        @(negedge clk);
        start = 1'b1; func = f; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bc = int'(busy);
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
    endtask

    initial begin
        vec_t        vt[8];
        int          lat, bc, n;
        logic [31:0] mhi, mlo, rb;
        logic        mdz;
        logic [5:0]  rf;
        vt[0] = '{6'd24, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vt[1] = '{6'd26, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vt[2] = '{6'd27, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
        vt[3] = '{6'd24, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[4] = '{6'd26, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5] = '{6'd27, 32'd9,        32'd4,        32'd1,        32'd2,        1'b0};
        vt[6] = '{6'd26, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vt[7] = '{6'd26, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

        #12;
        chk("reset_outputs", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        chk("multu_max_latency", 64'(lat), 64'd33);
        chk("multu_max_busy_cycles", 64'(bc), 64'd33);
        chk("multu_max_result", {hi, lo}, 64'hFFFFFFFE_00000001);
        chk("multu_max_dz", 64'(div_by_zero), 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(done), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].f, vt[i].a, vt[i].b, lat, bc);
            chk($sformatf("vec%0d_latency", i), 64'(lat), vt[i].edz ? 64'd1 : 64'd33);
            chk($sformatf("vec%0d_result", i), {hi, lo}, {vt[i].ehi, vt[i].elo});
            chk($sformatf("vec%0d_dz", i), 64'(div_by_zero), 64'(vt[i].edz));
        end

        // MTHI then MTLO on consecutive idle cycles
        @(negedge clk);
        start = 1'b1; func = 6'd17; rs_val = 32'h1234;
        #1 chk("idle_no_stall", 64'(stall), 64'd0);
        @(negedge clk);
        chk("mthi_no_busy", 64'(busy), 64'd0);
        func = 6'd19; rs_val = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_no_busy_done", {62'd0, busy, done}, 64'd0);
        chk("mthi_mtlo_values", {hi, lo}, 64'h00001234_00005678);

        // Read request and a new start while busy are stalled and ignored
        @(negedge clk);
        start = 1'b1; func = 6'd25; rs_val = 32'd3; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        read_req = 1'b1;
        #1 chk("stall_read_req", 64'(stall), 64'd1);
        @(negedge clk);
        read_req = 1'b0; start = 1'b1; func = 6'd17; rs_val = 32'hDEAD;
        #1 chk("stall_start", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_hilo_held", {hi, lo}, 64'h00001234_00005678);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stalled_op_done", 64'(done), 64'd1);
        chk("stalled_op_result", {hi, lo}, 64'd15);

        // Randomized ops, issued back-to-back in each done cycle
        for (int i = 0; i < 40; i++) begin
            rf = 6'd24 + 6'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            rs_val = $urandom;
            model(rf, rs_val, rb, mhi, mlo, mdz);
            run_op(rf, rs_val, rb, lat, bc);
            chk($sformatf("rand%0d_f%0d_result", i, rf), {hi, lo}, {mhi, mlo});
            chk($sformatf("rand%0d_dz_latency", i), {31'd0, div_by_zero, 32'(lat)}, {31'd0, mdz, mdz ? 32'd1 : 32'd33});
        end

        // Asynchronous reset in the middle of a calculation
        @(negedge clk);
        start = 1'b1; func = 6'd25; rs_val = 32'h12345; rt_val = 32'h777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_reset_mid_calc", {29'd0, busy, done, div_by_zero, hi, lo}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op(6'd27, 32'd9, 32'd4, lat, bc);
        chk("post_reset_divu", {hi, lo}, {32'd1, 32'd2});
        chk("post_reset_latency", 64'(lat), 64'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
